// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Purpose  : Drives a 4-digit multiplexed 7-segment display from a binary
//            score. A double-dabble FSM converts the score to BCD whenever it
//            changes; a scan counter rotates through the digits, leading zeros
//            are blanked, and an optional blink mode blanks the whole display
//            on alternate phases.
// Ports    : clk       - system clock, rising edge
//            reset     - asynchronous active-high reset
//            score     - 14-bit binary score (values > 9999 show as 9999)
//            blink_en  - 1 = blank the display on alternate blink phases
//            seg       - active-low segments {g,f,e,d,c,b,a}
//            an        - active-low digit enables, an[0] = rightmost digit
//            conv_busy - 1 while a binary-to-BCD conversion is running
// Revision : 1.0 - initial release
// ============================================================================
module score_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] score,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        conv_busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_load  = 2'd2;

    localparam int c_scan_w  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    // ------------------------------------------------------------------------
    // Binary-to-BCD converter
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [13:0] r_last_val;
    logic [13:0] r_shift;
    logic [15:0] r_bcd;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_digits;
    logic        r_busy;

    logic [13:0] w_clamped;
    logic [15:0] w_bcd_adj;
    logic [29:0] w_dd_next;

    assign w_clamped = (score > 14'd9999) ? 14'd9999 : score;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // BCD accumulator and binary shift register move left together as one word.
    assign w_dd_next = {w_bcd_adj, r_shift} << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_last_val <= '0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_bit_cnt  <= '0;
            r_digits   <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // Compare against the raw score so e.g. 12000 -> 13000
                    // still retriggers, even though both display as 9999.
                    if (score != r_last_val) begin
                        r_last_val <= score;
                        r_shift    <= w_clamped;
                        r_bcd      <= '0;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    r_bcd     <= w_dd_next[29:14];
                    r_shift   <= w_dd_next[13:0];
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd13)
                        r_state <= c_st_load;
                end
                c_st_load: begin
                    r_digits <= r_bcd;
                    r_busy   <= 1'b0;
                    r_state  <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign conv_busy = r_busy;

    // ------------------------------------------------------------------------
    // Digit scan and blink timing
    // ------------------------------------------------------------------------
    logic [c_scan_w-1:0]  r_scan_cnt;
    logic [1:0]           r_dig_idx;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= r_dig_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!blink_en) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (registered state only; score never reaches seg/an)
    // ------------------------------------------------------------------------
    logic [3:0] w_cur_digit;
    logic [1:0] w_msd;
    logic       w_lz_blank;
    logic [6:0] w_pattern;

    always_comb begin
        case (r_dig_idx)
            2'd0:    w_cur_digit = r_digits[3:0];
            2'd1:    w_cur_digit = r_digits[7:4];
            2'd2:    w_cur_digit = r_digits[11:8];
            default: w_cur_digit = r_digits[15:12];
        endcase
    end

    // Position of the most significant nonzero digit; digit 0 is always shown.
    always_comb begin
        if (r_digits[15:12] != 4'd0)     w_msd = 2'd3;
        else if (r_digits[11:8] != 4'd0) w_msd = 2'd2;
        else if (r_digits[7:4] != 4'd0)  w_msd = 2'd1;
        else                             w_msd = 2'd0;
    end

    assign w_lz_blank = (r_dig_idx > w_msd);

    always_comb begin
        case (w_cur_digit)
            4'd0:    w_pattern = 7'b1000000;
            4'd1:    w_pattern = 7'b1111001;
            4'd2:    w_pattern = 7'b0100100;
            4'd3:    w_pattern = 7'b0110000;
            4'd4:    w_pattern = 7'b0011001;
            4'd5:    w_pattern = 7'b0010010;
            4'd6:    w_pattern = 7'b0000010;
            4'd7:    w_pattern = 7'b1111000;
            4'd8:    w_pattern = 7'b0000000;
            4'd9:    w_pattern = 7'b0010000;
            default: w_pattern = 7'b1111111;
        endcase
    end

    assign seg = w_lz_blank ? 7'b1111111 : w_pattern;
    assign an  = (w_lz_blank || !r_blink_on) ? 4'b1111 : ~(4'b0001 << r_dig_idx);

endmodule
`default_nettype wire
